serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial addition controller that time-shares one external 1-bit full adder (fullAdder) to add two WIDTH-bit operands over WIDTH clock cycles, LSB first. It latches operands on a start handshake, drives the full adder's inputs each cycle, and captures the adder's sum and carry outputs. It returns the WIDTH-bit result and final carry with a one-cycle done pulse. It sits between a requesting unit and a single fullAdder instance, whose ports connect directly to the fa* ports below.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; accepted only in IDLE.
opA  input  WIDTH  operand A; sampled on the accepted start.
opB  input  WIDTH  operand B; sampled on the accepted start.
carryIn  input  1  initial carry; sampled on the accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  single-cycle pulse; result and carryOut are valid.
result  output  WIDTH  sum; holds until the next accepted start.
carryOut  output  1  final carry; holds like result.
faOp1  output  1  to fullAdder faOp1.
faOp2  output  1  to fullAdder faOp2.
faCi  output  1  to fullAdder faCi.
faRes  input  1  from fullAdder faRes (combinational).
faCo  input  1  from fullAdder faCo (combinational).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, carryOut=0; operand shift regs, carry reg and bit counter cleared. faOp1/faOp2/faCi=0. Reset mid-RUN aborts the operation; no done pulse is produced.
- Internal state: shA, shB (WIDTH-bit shift regs), cReg (1 bit), bitCnt (width clog2(WIDTH+1)), resSh (WIDTH-bit).
- FSM IDLE->RUN->DONE->IDLE.
- IDLE:
  - fa* outputs = 0.
  - On start=1: shA<=opA, shB<=opB, cReg<=carryIn, bitCnt<=0, resSh<=0. Next state RUN.
  - result and carryOut keep their previous values.
- RUN:
  - fa* outputs are combinational from state: faOp1=shA[0], faOp2=shB[0], faCi=cReg.
  - Each cycle: resSh<={faRes, resSh[WIDTH-1:1]}, cReg<=faCo, shA/shB shift right with zero fill, bitCnt<=bitCnt+1.
  - When bitCnt==WIDTH-1 in this cycle, next state is DONE.
- DONE (exactly one cycle):
  - done=1; result=resSh; carryOut=cReg. Both are registered on entry to DONE, so they are valid while done=1.
  - fa* outputs = 0. Next state IDLE.
- Latency: start accepted at edge k -> RUN occupies edges k+1..k+WIDTH -> done high during the cycle after edge k+WIDTH. Total WIDTH+1 cycles from accept to done.
- start in RUN or DONE is ignored; it is not queued. A new start is accepted the cycle after done, i.e. in IDLE; peak throughput is one add per WIDTH+2 cycles.
- Arithmetic: {carryOut,result} = opA + opB + carryIn, modulo 2^(WIDTH+1), unsigned.
- WIDTH=1: RUN lasts one cycle; the same rules apply.
- Operand inputs are don't-care outside the accepting cycle.

Test Plan:
- WIDTH=8, opA=0x5A, opB=0x3C, carryIn=0, start pulsed in IDLE -> busy high next cycle. done high exactly 9 cycles after the accept edge with result=0x96, carryOut=0. done low the following cycle.
- opA=0xFF, opB=0x01, carryIn=0 -> result=0x00, carryOut=1. Also check faCi=1 for RUN cycles 2..8.
- opA=0xFF, opB=0xFF, carryIn=1 -> result=0xFF, carryOut=1. Then start again with 0x00+0x00+0 in the cycle after done -> accepted; result=0x00, carryOut=0 after 9 more cycles. The previous result holds until the new done.
- Start 0x12+0x34, then hold start=1 and change operands to 0xAA/0x55 during RUN -> only one done; result=0x46. The second request is ignored.
- Start 0x80+0x80, assert rst_n=0 asynchronously at RUN cycle 4 -> all outputs 0 immediately; no done. After release, 0x01+0x02+1 gives result=0x04, carryOut=0.
- Random sweep of 1000 operand triples with a golden model -> {carryOut,result} matches opA+opB+carryIn. Exactly one done per accepted start.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/response bus between a requesting unit and serial_adder_ctrl
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             carryIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryOut;

  modport master (
    output start, opA, opB, carryIn,
    input  busy, done, result, carryOut
  );

  modport slave (
    input  start, opA, opB, carryIn,
    output busy, done, result, carryOut
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller time-sharing one external 1-bit full adder
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus,
  output logic                faOp1,
  output logic                faOp2,
  output logic                faCi,
  input  logic                faRes,
  input  logic                faCo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   sh_a_q;
  logic [WIDTH-1:0]   sh_b_q;
  logic [WIDTH-1:0]   res_sh_q;
  logic [WIDTH-1:0]   res_sh_d;
  logic [WIDTH-1:0]   result_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               c_q;
  logic               carry_out_q;
  logic               busy_q;
  logic               done_q;

  // Sum bits enter at the MSB so after WIDTH shifts the LSB-first stream is in place.
  always_comb begin
    res_sh_d            = res_sh_q >> 1;
    res_sh_d[WIDTH-1]   = faRes;
  end

  assign faOp1 = (state_q == RUN) & sh_a_q[0];
  assign faOp2 = (state_q == RUN) & sh_b_q[0];
  assign faCi  = (state_q == RUN) & c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      res_sh_q    <= '0;
      result_q    <= '0;
      bit_cnt_q   <= '0;
      c_q         <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sh_a_q    <= bus.opA;
            sh_b_q    <= bus.opB;
            c_q       <= bus.carryIn;
            bit_cnt_q <= '0;
            res_sh_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          res_sh_q  <= res_sh_d;
          c_q       <= faCo;
          sh_a_q    <= sh_a_q >> 1;
          sh_b_q    <= sh_b_q >> 1;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          // Last bit: capture the final sum/carry straight from the adder so they are valid with done.
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q    <= res_sh_d;
            carry_out_q <= faCo;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.carryOut = carry_out_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl with a behavioural full adder
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic faOp1, faOp2, faCi, faRes, faCo;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int accept_cnt = 0;
  logic [W:0] sb[$];

  serial_adder_ctrl_if #(.WIDTH(W)) sif ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif),
    .faOp1 (faOp1),
    .faOp2 (faOp2),
    .faCi  (faCi),
    .faRes (faRes),
    .faCo  (faCo)
  );

  assign faRes = faOp1 ^ faOp2 ^ faCi;
  assign faCo  = (faOp1 & faOp2) | (faOp1 & faCi) | (faOp2 & faCi);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sif.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual={%0b,0x%0h} expected=no_done", sif.carryOut, sif.result);
      end else begin
        chk("sum", {sif.carryOut, sif.result}, sb.pop_front());
      end
    end
  end

  // Issue from posedge+1 with the DUT idle; returns at the negedge where done is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic chk_prev, input logic [W:0] prev,
                       output int lat, output logic [15:0] hist);
    logic [W:0] e;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    sb.push_back(e);
    accept_cnt++;
    sif.start = 1'b1;
    sif.opA = a;
    sif.opB = b;
    sif.carryIn = c;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.opA = $urandom;
    sif.opB = $urandom;
    lat = 0;
    hist = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n < 16) hist[n] = faCi;
      if (chk_prev && n == 4) chk("result_hold", {sif.carryOut, sif.result}, prev);
      if (sif.done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int lat;
    logic [15:0] hist;
    logic [W-1:0] ra, rb;
    logic rc;

    sif.start = 1'b0;
    sif.opA = '0;
    sif.opB = '0;
    sif.carryIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {sif.busy, sif.done, sif.carryOut, sif.result, faOp1, faOp2, faCi}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x5A + 0x3C: busy next cycle, done on the 9th sampled cycle, then drops.
    sb.push_back(9'h096);
    accept_cnt++;
    sif.start = 1'b1;
    sif.opA = 8'h5A;
    sif.opB = 8'h3C;
    sif.carryIn = 1'b0;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    chk("busy_after_accept", sif.busy, 1'b1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sif.done) begin
        lat = n;
        break;
      end
    end
    chk("latency_5a_3c", lat, W + 1);
    @(negedge clk);
    chk("done_single_pulse", sif.done, 1'b0);
    @(posedge clk);
    #1;

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, '0, lat, hist);
    chk("latency_ff_01", lat, W + 1);
    chk("faCi_run_cycles", hist[8:1], 8'b1111_1110);
    @(posedge clk);
    #1;

    // Back-to-back: second start in the IDLE cycle right after done.
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, '0, lat, hist);
    @(posedge clk);
    #1;
    chk("idle_after_done", sif.busy, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1'b1, 9'h1FF, lat, hist);
    chk("latency_back_to_back", lat, W + 1);
    @(posedge clk);
    #1;

    // start held through RUN with new operands must not queue a second add.
    sb.push_back(9'h046);
    accept_cnt++;
    sif.start = 1'b1;
    sif.opA = 8'h12;
    sif.opB = 8'h34;
    sif.carryIn = 1'b0;
    @(posedge clk);
    #1;
    sif.opA = 8'hAA;
    sif.opB = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("held_start_drained", sb.size(), 0);

    // Asynchronous reset in RUN cycle 4 aborts the add.
    sb.push_back(9'h100);
    sif.start = 1'b1;
    sif.opA = 8'h80;
    sif.opB = 8'h80;
    sif.carryIn = 1'b0;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_outputs", {sif.busy, sif.done, sif.carryOut, sif.result, faOp1, faOp2, faCi}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt, accept_cnt);
    do_op(8'h01, 8'h02, 1'b1, 1'b0, '0, lat, hist);
    @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      do_op(ra, rb, rc, 1'b0, '0, lat, hist);
      @(posedge clk);
      #1;
    end

    repeat (12) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_per_accept", done_cnt, accept_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
